// File: rtl/aes_round_sequencer_pkg.sv
// rtl/aes_round_sequencer_pkg.sv - AES-128 state type, FSM encoding and GF(2^8) helpers (poly 0x11b)
package aes_round_sequencer_pkg;

  typedef logic [15:0][7:0] aes_state_t;

  localparam int NUM_ROUNDS_128 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Byte slot of s(r,c): byte 15 holds s(0,0), byte 14 holds s(1,0), column-major.
  function automatic logic [3:0] st_idx(input int r, input int c);
    return 4'(15 - 4 * c - r);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 = b^2 * b^4 * ... * b^128 (zero maps to zero), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One MixColumns column; result is {row0, row1, row2, row3}.
  function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_sequencer_mix_key.sv
// rtl/aes_round_sequencer_mix_key.sv - combinational ShiftRows, bypassable MixColumns and round-key XOR
module aes_mix_key
  import aes_round_sequencer_pkg::*;
(
  input  aes_state_t state_in,
  input  aes_state_t round_key,
  input  logic       bypass_mix,
  output aes_state_t state_out
);

  aes_state_t shifted;
  aes_state_t mixed;

  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[st_idx(r, c)] = state_in[st_idx(r, (c + r) % 4)];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      {mixed[st_idx(0, c)], mixed[st_idx(1, c)], mixed[st_idx(2, c)], mixed[st_idx(3, c)]} =
        mix_col(shifted[st_idx(0, c)], shifted[st_idx(1, c)],
                shifted[st_idx(2, c)], shifted[st_idx(3, c)]);
    end
  end

  assign state_out = (bypass_mix ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_round_sequencer_sbox.sv
// rtl/aes_round_sequencer_sbox.sv - AES S-box substitution over NBYTES independent bytes
module aes_substitute
  import aes_round_sequencer_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic [NBYTES-1:0][7:0] din,
  output logic [NBYTES-1:0][7:0] dout
);

  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    assign dout[i] = sbox(din[i]);
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES-128 round sequencer; SUB_SERIAL_EN selects column-serial SubBytes
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128,
  parameter int RND_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     plaintext,
  output logic [RND_W-1:0] rk_idx,
  input  logic [127:0]     round_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext,
  output logic             busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  fsm_e             fsm_q, fsm_d;
  aes_state_t       state_q, state_d;
  aes_state_t       ct_q, ct_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [RND_W-1:0] rk_idx_q, rk_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             step_done;
  logic             last_round;
  aes_state_t       mix_in;
  aes_state_t       mix_out;

  assign last_round = (round_q == LAST_RND);

`ifdef SUB_SERIAL_EN
  logic [1:0]      col_q, col_d;
  logic            mix_phase_q, mix_phase_d;
  logic [3:0][7:0] slice_in;
  logic [3:0][7:0] slice_out;

  always_comb begin
    slice_in = '0;
    for (int r = 0; r < 4; r++) begin
      slice_in[r] = state_q[st_idx(r, int'(col_q))];
    end
  end

  aes_substitute #(.NBYTES(4)) u_sub (
    .din  (slice_in),
    .dout (slice_out)
  );

  // Substitution is already folded into state_q by the time the mix cycle runs.
  assign mix_in = state_q;
`else
  aes_state_t sub_out;

  aes_substitute #(.NBYTES(16)) u_sub (
    .din  (state_q),
    .dout (sub_out)
  );

  assign mix_in = sub_out;
`endif

  aes_mix_key u_mix (
    .state_in   (mix_in),
    .round_key  (round_key),
    .bypass_mix (last_round),
    .state_out  (mix_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    round_d   = round_q;
    ct_d      = ct_q;
    step_done = 1'b0;
`ifdef SUB_SERIAL_EN
    col_d       = col_q;
    mix_phase_d = mix_phase_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ round_key;
          round_d = RND_W'(1);
          fsm_d   = RND;
`ifdef SUB_SERIAL_EN
          col_d       = 2'd0;
          mix_phase_d = 1'b0;
`endif
        end
      end
      RND: begin
`ifdef SUB_SERIAL_EN
        if (!mix_phase_q) begin
          for (int r = 0; r < 4; r++) begin
            state_d[st_idx(r, int'(col_q))] = slice_out[r];
          end
          if (col_q == 2'd3) mix_phase_d = 1'b1;
          else               col_d       = col_q + 2'd1;
        end else begin
          step_done   = 1'b1;
          mix_phase_d = 1'b0;
          col_d       = 2'd0;
        end
`else
        step_done = 1'b1;
`endif
        if (step_done) begin
          state_d = mix_out;
          if (last_round) begin
            fsm_d = DONE;
            ct_d  = mix_out;
          end else begin
            round_d = round_q + RND_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with fsm_q.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    rk_idx_d    = (fsm_d == RND) ? round_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      ct_q        <= '0;
      rk_idx_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUB_SERIAL_EN
      col_q       <= 2'd0;
      mix_phase_q <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      ct_q        <= ct_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SUB_SERIAL_EN
      col_q       <= col_d;
      mix_phase_q <= mix_phase_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign rk_idx     = rk_idx_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer; honours SUB_SERIAL_EN
module tb_aes_round_sequencer;

`ifdef SUB_SERIAL_EN
  localparam int STEP = 5;
`else
  localparam int STEP = 1;
`endif
  localparam int NR  = 10;
  localparam int LAT = NR * STEP + 1;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .rk_idx     (rk_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           last_lat = 0;
  bit           chk_en  = 1'b0;
  int           sb [256];
  logic [127:0] rk_tab [0:10];

  // External key store: combinational lookup of the requested round key.
  always_comb round_key = (int'(rk_idx) <= NR) ? rk_tab[int'(rk_idx)] : '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  // S-box from first principles: brute-force multiplicative inverse, bitwise affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s = 0;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      for (int i = 0; i < 8; i++) begin
        int bit_i;
        bit_i = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                 (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bit_i << i);
      end
      sb[x] = s;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rcon = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {8'(sb[t[31:24]]) ^ 8'(rcon), 8'(sb[t[23:16]]), 8'(sb[t[15:8]]), 8'(sb[t[7:0]])};
        rcon = gmul(rcon, 2);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    int b [16];
    int t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = int'(pt[127 - 8 * i -: 8]) ^ int'(rk_tab[0][127 - 8 * i -: 8]);
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int i = 0; i < 16; i++) b[i] = sb[b[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4 * c + r] = b[4 * ((c + r) % 4) + r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < NR)
            b[4 * c + r] = gmul(2, t[4 * c + r]) ^ gmul(3, t[4 * c + (r + 1) % 4]) ^
                           t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
          else
            b[4 * c + r] = t[4 * c + r];
      for (int i = 0; i < 16; i++) b[i] = b[i] ^ int'(rk_tab[rnd][127 - 8 * i -: 8]);
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = 8'(b[i]);
    return res;
  endfunction

  // Occupancy model: 0 idle, 1 running (m_cnt cycles since accept), 2 holding result.
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [127:0] m_ct    = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_ct    = model_encrypt(plaintext);
          m_cnt   = 0;
          m_phase = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NR * STEP) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 128'(in_ready), 128'(m_phase == 0));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_phase == 2));
      chk("cyc_busy", 128'(busy), 128'(m_phase != 0));
      if (m_phase == 0)      chk("cyc_rk_idx_idle", 128'(rk_idx), 128'(0));
      else if (m_phase == 1) chk("cyc_rk_idx_rnd", 128'(rk_idx), 128'(1 + m_cnt / STEP));
      else                   chk("cyc_ct", ciphertext, m_ct);
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clk);
    expand_key(key);
    plaintext = pt;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic finish_block(input string name, input logic [127:0] exp_ct, input int hold);
    int n = 1;
    while (out_valid !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    chk({name, "_valid"}, 128'(out_valid), 128'(1));
    chk(name, ciphertext, exp_ct);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_bp_ct"}, ciphertext, exp_ct);
      chk({name, "_bp_valid"}, 128'(out_valid), 128'(1));
      chk({name, "_bp_in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] exp2;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    for (int r = 0; r <= NR; r++) rk_tab[r] = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    chk("rst_ct", ciphertext, 128'h0);

    chk("pin_sbox_00", 128'(sb[0]), 128'h63);
    chk("pin_sbox_53", 128'(sb['h53]), 128'hed);
    expand_key(KEY_B);
    chk("pin_round1_state", PT_B ^ rk_tab[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("pin_rk10_b", rk_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_model_b", model_encrypt(PT_B), CT_B);
    expand_key(KEY_C);
    chk("pin_model_c", model_encrypt(PT_C), CT_C);
    expand_key(128'h0);
    chk("pin_model_zero", model_encrypt(128'h0), CT_Z);

    reset  = 1'b0;
    chk_en = 1'b1;

    send(PT_B, KEY_B);
    finish_block("ct_app_b", CT_B, 0);

    send(PT_C, KEY_C);
    finish_block("ct_app_c", CT_C, 0);
    chk("latency", 128'(last_lat), 128'(LAT));

    send(PT_B, KEY_B);
    finish_block("ct_backpressure", CT_B, 20);

    send(PT_C, KEY_C);
    n = 0;
    while (rk_idx != 4'd5 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("reach_round5", 128'(rk_idx), 128'(5));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    send(128'h0, 128'h0);
    finish_block("ct_after_abort", CT_Z, 0);

    // Back-to-back with in_valid held high; second block uses the same key.
    @(negedge clk);
    expand_key(KEY_B);
    plaintext = PT_B;
    in_valid  = 1'b1;
    @(negedge clk);
    plaintext = PT_C;
    exp2      = model_encrypt(PT_C);
    n = 1;
    while (out_valid !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ct1", ciphertext, CT_B);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_gap_in_ready", 128'(in_ready), 128'(1));
    chk("b2b_gap_busy", 128'(busy), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accept", 128'(busy), 128'(1));
    finish_block("b2b_ct2", exp2, 0);

    @(negedge clk);
    expand_key(KEY_C);
    plaintext = PT_C;
    in_valid  = 1'b1;
    chk("trace_idle", 128'(rk_idx), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    for (int v = 1; v <= NR; v++) begin
      for (int k = 0; k < STEP; k++) begin
        chk("rk_trace", 128'(rk_idx), 128'(v));
        @(negedge clk);
      end
    end
    chk("trace_end_valid", 128'(out_valid), 128'(1));
    chk("trace_ct", ciphertext, CT_C);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1);
  end

endmodule
